// File: rtl/gaussian3x3_stream.sv
// Streaming 3x3 Gaussian blur [1 2 1; 2 4 2; 1 2 1]/16 over a valid/ready pixel stream.
// Define GAUSS_ROUND_EN for round-half-up scaling; the default build truncates.
module gaussian3x3_stream #(
  parameter int PIXEL_BIT_WIDTH  = 12,
  parameter int ROWS             = 20,
  parameter int COLS             = 20,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA,
  input  logic                       pixel_in_TVALID,
  output logic                       pixel_in_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA,
  output logic                       pixel_out_TVALID,
  input  logic                       pixel_out_TREADY,
  output logic                       pixel_out_TLAST
);

  localparam int SUM_W = PIXEL_BIT_WIDTH + 4;
  localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [IMG_ROW_BITWIDTH-1:0] LAST_ROW = IMG_ROW_BITWIDTH'(ROWS - 1);
  localparam logic [IMG_COL_BITWIDTH-1:0] LAST_COL = IMG_COL_BITWIDTH'(COLS - 1);
  localparam logic [IMG_ROW_BITWIDTH-1:0] MIN_ROW  = IMG_ROW_BITWIDTH'(2);
  localparam logic [IMG_COL_BITWIDTH-1:0] MIN_COL  = IMG_COL_BITWIDTH'(2);

  logic [PIXEL_BIT_WIDTH-1:0] linebuf0 [COLS];
  logic [PIXEL_BIT_WIDTH-1:0] linebuf1 [COLS];
  // Two left columns of the window; the right column is the incoming one.
  logic [PIXEL_BIT_WIDTH-1:0] win [3][2];

  logic [IMG_ROW_BITWIDTH-1:0] row;
  logic [IMG_COL_BITWIDTH-1:0] col;
  logic [IDX_W-1:0]            col_idx;
  logic                        accept;
  logic                        complete;
  logic                        end_of_row;
  logic                        end_of_frame;
  logic [PIXEL_BIT_WIDTH-1:0]  tap_top;
  logic [PIXEL_BIT_WIDTH-1:0]  tap_mid;
  logic [SUM_W-1:0]            sum_p0;

  function automatic logic [SUM_W-1:0] ext(input logic [PIXEL_BIT_WIDTH-1:0] v);
    return SUM_W'(v);
  endfunction

  // sum <= 16*max, so both variants fit back into the pixel width
  function automatic logic [PIXEL_BIT_WIDTH-1:0] scale_sum(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] t;
`ifdef GAUSS_ROUND_EN
    t = s + SUM_W'(8);
`else
    t = s;
`endif
    return t[SUM_W-1:4];
  endfunction

  assign pixel_in_TREADY = reset & (~pixel_out_TVALID | pixel_out_TREADY);
  assign accept          = pixel_in_TVALID & pixel_in_TREADY;
  assign col_idx         = col[IDX_W-1:0];
  assign end_of_row      = (col == LAST_COL);
  assign end_of_frame    = end_of_row & (row == LAST_ROW);
  assign complete        = (row >= MIN_ROW) & (col >= MIN_COL);
  assign tap_top         = linebuf1[col_idx];
  assign tap_mid         = linebuf0[col_idx];

  assign sum_p0 = ext(win[0][0]) + (ext(win[0][1]) << 1) + ext(tap_top)
                + (ext(win[1][0]) << 1) + (ext(win[1][1]) << 2) + (ext(tap_mid) << 1)
                + ext(win[2][0]) + (ext(win[2][1]) << 1) + ext(pixel_in_TDATA);

  always_ff @(posedge clk) begin
    if (accept) begin
      linebuf1[col_idx] <= tap_mid;
      linebuf0[col_idx] <= pixel_in_TDATA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= '0;
        win[i][1] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < 3; i++) win[i][0] <= win[i][1];
      win[0][1] <= tap_top;
      win[1][1] <= tap_mid;
      win[2][1] <= pixel_in_TDATA;
      if (end_of_row) begin
        col <= '0;
        row <= end_of_frame ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // ---- p0 -> output register boundary ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_out_TVALID <= 1'b0;
      pixel_out_TDATA  <= '0;
      pixel_out_TLAST  <= 1'b0;
    end else if (accept && complete) begin
      pixel_out_TVALID <= 1'b1;
      pixel_out_TDATA  <= scale_sum(sum_p0);
      pixel_out_TLAST  <= end_of_frame;
    end else if (pixel_out_TREADY) begin
      pixel_out_TVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gaussian3x3_stream.sv
// Scoreboard bench for gaussian3x3_stream: a 4x4 instance for directed/random frames,
// a 20x20 instance for the full-scale saturation frame.
module tb_gaussian3x3_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [11:0] in_data4, out_data4, in_data20, out_data20;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_last4;
  logic        in_valid20, in_ready20, out_valid20, out_ready20, out_last20;

  gaussian3x3_stream #(.PIXEL_BIT_WIDTH(12), .ROWS(4), .COLS(4),
                       .IMG_ROW_BITWIDTH(10), .IMG_COL_BITWIDTH(10)) dut4 (
    .clk(clk), .reset(reset),
    .pixel_in_TDATA(in_data4), .pixel_in_TVALID(in_valid4), .pixel_in_TREADY(in_ready4),
    .pixel_out_TDATA(out_data4), .pixel_out_TVALID(out_valid4),
    .pixel_out_TREADY(out_ready4), .pixel_out_TLAST(out_last4));

  gaussian3x3_stream #(.PIXEL_BIT_WIDTH(12), .ROWS(20), .COLS(20),
                       .IMG_ROW_BITWIDTH(10), .IMG_COL_BITWIDTH(10)) dut20 (
    .clk(clk), .reset(reset),
    .pixel_in_TDATA(in_data20), .pixel_in_TVALID(in_valid20), .pixel_in_TREADY(in_ready20),
    .pixel_out_TDATA(out_data20), .pixel_out_TVALID(out_valid20),
    .pixel_out_TREADY(out_ready20), .pixel_out_TLAST(out_last20));

  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] exp4[$];
  logic [12:0] exp20[$];
  logic [12:0] e4, e20;
  int frame[400];
  int kern[3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
  int bp_mode = 0;   // 0: always ready, 1: random ready, 2: never ready
  bit stall_req = 1'b0;
  int out_count20 = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int scale_ref(input int s);
`ifdef GAUSS_ROUND_EN
    return (s + 8) / 16;
`else
    return s / 16;
`endif
  endfunction

  // Reference: convolve every interior centre of frame[] in raster order.
  task automatic model(input int rows, input int cols, input bit big);
    for (int r = 1; r <= rows - 2; r++)
      for (int c = 1; c <= cols - 2; c++) begin
        int s;
        logic [12:0] e;
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += kern[i][j] * frame[(r + i - 1) * cols + (c + j - 1)];
        e[11:0] = 12'(scale_ref(s));
        e[12]   = (r == rows - 2) && (c == cols - 2);
        if (big) exp20.push_back(e); else exp4.push_back(e);
      end
  endtask

  // Output monitor / scoreboard for both instances.
  always @(negedge clk) begin
    if (reset && out_valid4 && out_ready4) begin
      if (exp4.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut4_extra: got output %0d, required no output", out_data4);
      end else begin
        e4 = exp4.pop_front();
        check("dut4_data", int'(out_data4), int'(e4[11:0]));
        check("dut4_last", int'(out_last4), int'(e4[12]));
      end
    end
    if (reset && out_valid20 && out_ready20) begin
      out_count20++;
      if (exp20.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut20_extra: got output %0d, required no output", out_data20);
      end else begin
        e20 = exp20.pop_front();
        check("dut20_data", int'(out_data20), int'(e20[11:0]));
        check("dut20_last", int'(out_last20), int'(e20[12]));
      end
    end
  end

  // Downstream ready generator, including the 5-cycle stall with hold checks.
  initial begin
    logic [11:0] hd;
    logic        hl;
    out_ready4 = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_req && out_valid4) begin
        out_ready4 = 1'b0;
        hd = out_data4;
        hl = out_last4;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", int'(out_valid4), 1);
          check("stall_data", int'(out_data4), int'(hd));
          check("stall_last", int'(out_last4), int'(hl));
          check("stall_in_ready", int'(in_ready4), 0);
          @(posedge clk); #1;
        end
        out_ready4 = 1'b1;
        stall_req  = 1'b0;
      end else begin
        case (bp_mode)
          0:       out_ready4 = 1'b1;
          1:       out_ready4 = ($urandom_range(0, 3) != 0);
          default: out_ready4 = 1'b0;
        endcase
      end
    end
  end

  task automatic drive4(input int n, input bit gaps, output int low);
    low = 0;
    for (int i = 0; i < n; i++) begin
      bit got;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid4 = 1'b0;
        @(posedge clk); #1;
      end
      in_data4  = 12'(frame[i]);
      in_valid4 = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        if (in_ready4) got = 1'b1; else low++;
      end
      if (!got) begin
        n_fail++;
        $display("FAIL dut4_in_timeout: got no ready after 200 cycles, required ready");
        $fatal(1, "input handshake timeout");
      end
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
  endtask

  task automatic drain4();
    for (int t = 0; t < 2000 && exp4.size() != 0; t++) @(posedge clk);
    #1 check("dut4_drain", exp4.size(), 0);
  endtask

  initial begin
    int low;
    reset = 1'b0;
    in_valid4 = 1'b0;  in_data4 = '0;
    in_valid20 = 1'b0; in_data20 = '0; out_ready20 = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid4), 0);
    check("rst_out_data", int'(out_data4), 0);
    check("rst_out_last", int'(out_last4), 0);
    check("rst_in_ready", int'(in_ready4), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("post_rst_in_ready", int'(in_ready4), 1);

    // Flat 100s: four outputs of 100, ready never drops.
    for (int i = 0; i < 16; i++) frame[i] = 100;
    model(4, 4, 0);
    drive4(16, 0, low);
    check("flat_in_ready_low_cycles", low, 0);
    drain4();

    // Impulses at (1,1): 160 and then 2 (rounding boundary).
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) frame[i] = 0;
      frame[5] = (k == 0) ? 160 : 2;
      model(4, 4, 0);
      drive4(16, 0, low);
      drain4();
    end

    // Full-scale 20x20 frame: 324 outputs of 4095.
    for (int i = 0; i < 400; i++) frame[i] = 4095;
    model(20, 20, 1);
    for (int i = 0; i < 400; i++) begin
      bit got;
      in_data20 = 12'(frame[i]);
      in_valid20 = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        if (in_ready20) got = 1'b1;
      end
      if (!got) begin
        n_fail++;
        $display("FAIL dut20_in_timeout: got no ready after 200 cycles, required ready");
        $fatal(1, "input handshake timeout");
      end
      @(posedge clk); #1;
    end
    in_valid20 = 1'b0;
    for (int t = 0; t < 2000 && exp20.size() != 0; t++) @(posedge clk);
    #1 check("dut20_drain", exp20.size(), 0);
    check("dut20_out_count", out_count20, 324);

    // Random back-to-back frames with random input gaps and output backpressure.
    bp_mode = 1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) frame[i] = int'($urandom_range(0, 4095));
      model(4, 4, 0);
      drive4(16, 1, low);
    end
    drain4();
    bp_mode = 0;

    // Explicit 5-cycle stall on the first valid output.
    for (int i = 0; i < 16; i++) frame[i] = int'($urandom_range(0, 4095));
    stall_req = 1'b1;
    model(4, 4, 0);
    drive4(16, 0, low);
    drain4();
    check("stall_taken", int'(stall_req), 0);

    // Async reset while an output is being held: valid must drop immediately.
    for (int i = 0; i < 16; i++) frame[i] = 100;
    bp_mode = 2;
    drive4(11, 0, low);
    @(negedge clk);
    check("held_valid_before_rst", int'(out_valid4), 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", int'(out_valid4), 0);
    check("async_rst_data", int'(out_data4), 0);
    check("async_rst_in_ready", int'(in_ready4), 0);
    @(posedge clk); #1 reset = 1'b1;
    bp_mode = 0;

    // Reset after 7 pixels, then a clean frame of 100s.
    for (int i = 0; i < 16; i++) frame[i] = int'($urandom_range(0, 4095));
    drive4(7, 0, low);
    #3 reset = 1'b0;
    #1 check("mid_rst_valid", int'(out_valid4), 0);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 16; i++) frame[i] = 100;
    model(4, 4, 0);
    drive4(16, 0, low);
    drain4();
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gaussian3x3_stream.md
Name: gaussian3x3_stream

Overview:
- Streaming 3x3 Gaussian blur stage that sits directly downstream of the crop/FIFO stage.
- Consumes the cropped image (ROWS x COLS pixels, raster order) over a valid/ready stream and produces the valid-region blurred image, (ROWS-2) x (COLS-2) pixels, over a valid/ready stream.
- Keeps two line buffers plus a 3x3 window register so that full-rate streaming needs no frame store.

Parameters:
- PIXEL_BIT_WIDTH, 12, pixel data width (input and output).
- ROWS, 20, input image rows; must be >= 3.
- COLS, 20, input image columns; must be >= 3.
- IMG_ROW_BITWIDTH, 10, row counter width.
- IMG_COL_BITWIDTH, 10, column counter width.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- pixel_in_TDATA  input  PIXEL_BIT_WIDTH  input pixel.
- pixel_in_TVALID  input  1  input pixel valid.
- pixel_in_TREADY  output  1  block accepts input.
- pixel_out_TDATA  output  PIXEL_BIT_WIDTH  blurred pixel.
- pixel_out_TVALID  output  1  output pixel valid.
- pixel_out_TREADY  input  1  downstream accepts output.
- pixel_out_TLAST  output  1  high with the last output pixel of a frame.

Behaviour:
- Handshake and reset
  - Transfer occurs on any cycle where TVALID && TREADY.
  - While reset=0, asynchronously: pixel_out_TVALID=0, pixel_out_TDATA=0, pixel_out_TLAST=0, row and column counters=0, window registers=0. Line buffer RAM contents are don't-care.
  - pixel_in_TREADY = !pixel_out_TVALID || pixel_out_TREADY (combinational; single output register). It is 0 during reset.
- Per accepted input pixel p at (r,c)
  - Shift the window left one column.
  - New right column = {linebuf1[c], linebuf0[c], p}, top to bottom.
  - Write linebuf1[c] <= linebuf0[c] and linebuf0[c] <= p.
  - Advance c; on c == COLS-1, wrap c to 0 and advance r; on r == ROWS-1 && c == COLS-1, wrap both to 0 (next frame begins).
- Output generation
  - Window complete when r >= 2 && c >= 2; the output is centred on (r-1, c-1).
  - Result is registered: pixel_out_TVALID=1 on the cycle after the accepting edge (latency 1 cycle from acceptance of the completing pixel).
  - Non-complete positions (first two rows, first two columns of each row) produce no output; the input is still accepted.
- Arithmetic
  - Kernel [1 2 1; 2 4 2; 1 2 1].
  - Weighted sum computed at PIXEL_BIT_WIDTH+4 bits unsigned, never overflows.
  - Result = sum >> 4 (rounding controlled by the optional feature); always fits in PIXEL_BIT_WIDTH.
- Output hold
  - pixel_out_TVALID, TDATA and TLAST hold stable until pixel_out_TREADY=1.
  - Simultaneous output drain and new input accept in the same cycle is allowed (full throughput, one pixel/cycle).
- pixel_out_TLAST = 1 with the output for centre (ROWS-2, COLS-2), i.e. the input at (ROWS-1, COLS-1).
- Frames are back-to-back; there are no stale-row windows because output is gated by r >= 2.
- Reset mid-frame: all state clears and the next accepted pixel is treated as (0,0).

Optional Feature:
- Macro GAUSS_ROUND_EN.
  - Defined: result = (sum + 8) >> 4, i.e. round half up. This cannot exceed the max pixel value because sum <= 16*max.
  - Undefined: result = sum >> 4 (truncate).

Test Plan:
- ROWS=COLS=4, every pixel 100, pixel_out_TREADY=1 -> exactly 4 outputs, all 100, TLAST only on the 4th; in_TREADY constantly 1.
- ROWS=COLS=4, all zeros except (1,1)=160 -> outputs in order 40, 20, 20, 10.
- ROWS=COLS=4, all zeros except (1,1)=2 -> first output is 1 with GAUSS_ROUND_EN defined and 0 without; the other three outputs are 0 with GAUSS_ROUND_EN defined (2*2/16 -> 0) and 0 without.
- ROWS=COLS=20, all pixels 4095 -> 324 outputs, all 4095 (no overflow), TLAST on output 324 only.
- Backpressure: hold pixel_out_TREADY=0 for 5 cycles while an output is valid -> TDATA and TLAST stable, pixel_in_TREADY=0, no input consumed. After release, the sequence matches the no-stall run exactly.
- Drive reset=0 asynchronously mid-frame (after 7 pixels) -> TVALID drops immediately. The next full 4x4 frame of 100s yields exactly 4 outputs of 100.
